// File: rtl/fog_param_sequencer.sv
// Parameter commit sequencer for a fibre-optic gyro loop.
// The host writes a shadow register bank. An apply request arms the
// sequencer. The next step-trigger edge copies the shadows into the active
// bank in one cycle, then the sequencer holds busy for SETTLE_STEPS further
// step edges so the loop can settle before another commit.
module fog_param_sequencer #(
  parameter int SETTLE_STEPS = 2,
  parameter int AVG_MAX      = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_apply_req,
  input  logic        i_step_trig,
  input  logic        i_err_clr,
  output logic        o_wr_ack,
  output logic [31:0] o_freq_cnt,
  output logic [31:0] o_amp_H,
  output logic [31:0] o_amp_L,
  output logic [31:0] o_avg_sel,
  output logic [31:0] o_err_offset,
  output logic [31:0] o_wait_cnt,
  output logic        o_polarity,
  output logic        o_update,
  output logic        o_busy,
  output logic        o_dirty,
  output logic        o_err_flag,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_APPLY = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Shadow register addresses
  localparam logic [3:0] ADDR_FREQ     = 4'd0;
  localparam logic [3:0] ADDR_AMP_H    = 4'd1;
  localparam logic [3:0] ADDR_AMP_L    = 4'd2;
  localparam logic [3:0] ADDR_AVG      = 4'd3;
  localparam logic [3:0] ADDR_ERR_OFF  = 4'd4;
  localparam logic [3:0] ADDR_POLARITY = 4'd5;
  localparam logic [3:0] ADDR_WAIT     = 4'd6;

  // Power-on parameter set, shared by shadow and active banks
  localparam logic [31:0] RST_FREQ    = 32'd221;
  localparam logic [31:0] RST_AMP_H   = 32'd3000;
  localparam logic [31:0] RST_AMP_L   = 32'(-3000);
  localparam logic [31:0] RST_AVG     = 32'd6;
  localparam logic [31:0] RST_ERR_OFF = 32'd0;
  localparam logic        RST_POL     = 1'b0;
  localparam logic [31:0] RST_WAIT    = 32'd75;

  localparam logic [31:0] AVG_MAX_W = 32'(AVG_MAX);
  localparam logic [31:0] FREQ_MIN  = 32'd2;

  // The HOLD counter only needs to reach SETTLE_STEPS-1
  localparam int              HCW       = (SETTLE_STEPS < 2) ? 1 : $clog2(SETTLE_STEPS);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'((SETTLE_STEPS == 0) ? 0 : SETTLE_STEPS - 1);

  state_t state, state_nxt;

  logic [31:0] sh_freq, sh_amp_h, sh_amp_l, sh_avg, sh_err_off, sh_wait;
  logic        sh_pol;
  logic        dirty;
  logic        queued;
  logic        step_prev;
  logic [HCW-1:0] hold_cnt;

  logic step_edge;
  logic wr_bad_addr;
  logic wr_bad_freq;
  logic wr_ok;
  logic amp_valid;
  logic do_copy;
  logic apply_fail;
  logic err_set;
  logic [31:0] wait_clamped;

  // Decode step edge, write legality, and apply validity
  always_comb begin
    step_edge    = i_step_trig & ~step_prev;
    wr_bad_addr  = i_wr_en && (i_wr_addr > ADDR_WAIT);
    wr_bad_freq  = i_wr_en && (i_wr_addr == ADDR_FREQ) && (i_wr_data < FREQ_MIN);
    wr_ok        = i_wr_en && !wr_bad_addr && !wr_bad_freq;
    amp_valid    = $signed(sh_amp_h) > $signed(sh_amp_l);
    do_copy      = (state == S_APPLY) && amp_valid;
    apply_fail   = (state == S_APPLY) && !amp_valid;
    err_set      = wr_bad_addr || wr_bad_freq || apply_fail;
    // The active wait count must stay below the active period
    wait_clamped = (sh_wait >= sh_freq) ? (sh_freq - 32'd1) : sh_wait;
  end

  // State register
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers sample pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: the default assignment up front keeps this block free of
    // inferred latches when no branch below overrides it.
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if ((i_apply_req || queued) && dirty) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (step_edge) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        if (!amp_valid || (SETTLE_STEPS == 0)) state_nxt = S_IDLE;
        else                                   state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (step_edge && (hold_cnt == HOLD_LAST)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    o_busy  = (state != S_IDLE);
    o_state = state;
  end

  // Host write path into the shadow bank, with per-field write rules
  // NOTE: every register here has an explicit reset value; the parameter
  // banks are plain flops, not a memory, so they reset like control state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_freq    <= RST_FREQ;
      sh_amp_h   <= RST_AMP_H;
      sh_amp_l   <= RST_AMP_L;
      sh_avg     <= RST_AVG;
      sh_err_off <= RST_ERR_OFF;
      sh_pol     <= RST_POL;
      sh_wait    <= RST_WAIT;
      o_wr_ack   <= 1'b0;
    end else begin
      o_wr_ack <= i_wr_en;
      if (wr_ok) begin
        unique case (i_wr_addr)
          ADDR_FREQ:     sh_freq    <= i_wr_data;
          ADDR_AMP_H:    sh_amp_h   <= i_wr_data;
          ADDR_AMP_L:    sh_amp_l   <= i_wr_data;
          ADDR_AVG:      sh_avg     <= (i_wr_data > AVG_MAX_W) ? AVG_MAX_W : i_wr_data;
          ADDR_ERR_OFF:  sh_err_off <= i_wr_data;
          ADDR_POLARITY: sh_pol     <= i_wr_data[0];
          ADDR_WAIT:     sh_wait    <= i_wr_data;
          default:       ;
        endcase
      end
    end
  end

  // Commit of the shadow bank into the active outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_freq_cnt   <= RST_FREQ;
      o_amp_H      <= RST_AMP_H;
      o_amp_L      <= RST_AMP_L;
      o_avg_sel    <= RST_AVG;
      o_err_offset <= RST_ERR_OFF;
      o_polarity   <= RST_POL;
      o_wait_cnt   <= RST_WAIT;
      o_update     <= 1'b0;
    end else begin
      o_update <= do_copy;
      if (do_copy) begin
        o_freq_cnt   <= sh_freq;
        o_amp_H      <= sh_amp_h;
        o_amp_L      <= sh_amp_l;
        o_avg_sel    <= sh_avg;
        o_err_offset <= sh_err_off;
        o_polarity   <= sh_pol;
        o_wait_cnt   <= wait_clamped;
      end
    end
  end

  // Sequencing bookkeeping: dirty, queued request, step history, settle count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dirty     <= 1'b0;
      queued    <= 1'b0;
      step_prev <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      step_prev <= i_step_trig;

      // A write that coincides with the copy wins, so the new value is not lost
      if (wr_ok)        dirty <= 1'b1;
      else if (do_copy) dirty <= 1'b0;

      // The queued request is consumed on the first IDLE cycle
      if (state == S_IDLE)  queued <= 1'b0;
      else if (i_apply_req) queued <= 1'b1;

      if (state != S_HOLD) hold_cnt <= '0;
      else if (step_edge)  hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       o_err_flag <= 1'b0;
    else if (err_set)   o_err_flag <= 1'b1;
    else if (i_err_clr) o_err_flag <= 1'b0;
  end

  assign o_dirty = dirty;

endmodule

// File: tb/tb_fog_param_sequencer.sv
// Self-checking bench for fog_param_sequencer. A transaction-level model
// tracks the shadow bank, active bank, dirty and error state; directed
// scenarios and a randomized write/apply loop are compared against it.
module tb_fog_param_sequencer;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        apply_req = 1'b0;
  logic        step_trig = 1'b0;
  logic        err_clr = 1'b0;

  logic        o_wr_ack;
  logic [31:0] o_freq_cnt, o_amp_H, o_amp_L, o_avg_sel, o_err_offset, o_wait_cnt;
  logic        o_polarity, o_update, o_busy, o_dirty, o_err_flag;
  logic [1:0]  o_state;

  int errors = 0;
  int checks = 0;

  // Model state: index = register address
  logic [31:0] m_sh[7];
  logic [31:0] m_act[7];
  bit          m_dirty;
  bit          m_err;

  fog_param_sequencer #(.SETTLE_STEPS(SETTLE), .AVG_MAX(7)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_apply_req(apply_req), .i_step_trig(step_trig),
    .i_err_clr(err_clr), .o_wr_ack(o_wr_ack), .o_freq_cnt(o_freq_cnt),
    .o_amp_H(o_amp_H), .o_amp_L(o_amp_L), .o_avg_sel(o_avg_sel),
    .o_err_offset(o_err_offset), .o_wait_cnt(o_wait_cnt), .o_polarity(o_polarity),
    .o_update(o_update), .o_busy(o_busy), .o_dirty(o_dirty),
    .o_err_flag(o_err_flag), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_sh[0] = 32'd221; m_sh[1] = 32'd3000; m_sh[2] = 32'(-3000);
    m_sh[3] = 32'd6;   m_sh[4] = 32'd0;    m_sh[5] = 32'd0; m_sh[6] = 32'd75;
    m_act   = m_sh;
    m_dirty = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_write(input int addr, input logic [31:0] data);
    logic [31:0] v;
    if (addr > 6)                   m_err = 1'b1;
    else if (addr == 0 && data < 2) m_err = 1'b1;
    else begin
      v = data;
      if (addr == 3 && data > 7) v = 32'd7;
      if (addr == 5)             v = {31'b0, data[0]};
      m_sh[addr] = v;
      m_dirty    = 1'b1;
    end
  endfunction

  function automatic bit model_apply();
    if ($signed(m_sh[1]) > $signed(m_sh[2])) begin
      m_act = m_sh;
      if (m_sh[6] >= m_sh[0]) m_act[6] = m_sh[0] - 1;
      m_dirty = 1'b0;
      return 1'b1;
    end
    m_err = 1'b1;
    return 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input int addr, input logic [31:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    model_write(addr, data);
    checks++;
    if (o_wr_ack !== 1'b1) begin
      errors++; $display("FAIL wr_ack addr=%0d got %b expected 1", addr, o_wr_ack);
    end
  endtask

  task automatic pulse_step();
    @(negedge clk) step_trig = 1'b1;
    @(negedge clk) step_trig = 1'b0;
  endtask

  task automatic pulse_apply();
    @(negedge clk) apply_req = 1'b1;
    @(negedge clk) apply_req = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    m_err = 1'b0;
    checks++;
    if (o_err_flag !== 1'b0) begin
      errors++; $display("FAIL err_clr got %b expected 0", o_err_flag);
    end
  endtask

  task automatic compare_actives(input string tag);
    logic [31:0] obs[7];
    obs = '{o_freq_cnt, o_amp_H, o_amp_L, o_avg_sel, o_err_offset,
            {31'b0, o_polarity}, o_wait_cnt};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (obs[i] !== m_act[i]) begin
        errors++;
        $display("FAIL %s active[%0d] got %0h expected %0h", tag, i, obs[i], m_act[i]);
      end
    end
  endtask

  task automatic check_status(input string tag, input logic [1:0] st);
    checks++;
    if (o_state !== st || o_busy !== (st != 2'd0) || o_dirty !== m_dirty ||
        o_err_flag !== m_err) begin
      errors++;
      $display("FAIL %s status got st=%0d busy=%b dirty=%b err=%b expected st=%0d busy=%b dirty=%b err=%b",
               tag, o_state, o_busy, o_dirty, o_err_flag, st, (st != 2'd0), m_dirty, m_err);
    end
  endtask

  // Full apply: request, step edge, commit, settle
  task automatic run_apply(input string tag);
    bit valid;
    pulse_apply();
    if (!m_dirty) begin
      check_status({tag, "_noop"}, 2'd0);
      return;
    end
    check_status({tag, "_armed"}, 2'd1);
    pulse_step();
    check_status({tag, "_apply"}, 2'd2);
    valid = model_apply();
    @(negedge clk);
    checks++;
    if (o_update !== valid) begin
      errors++; $display("FAIL %s update got %b expected %b", tag, o_update, valid);
    end
    compare_actives(tag);
    if (!valid) begin
      check_status({tag, "_reject"}, 2'd0);
      return;
    end
    check_status({tag, "_hold"}, 2'd3);
    @(negedge clk);
    checks++;
    if (o_update !== 1'b0) begin
      errors++; $display("FAIL %s update_width got %b expected 0", tag, o_update);
    end
    for (int i = 0; i < SETTLE - 1; i++) begin
      pulse_step();
      check_status({tag, "_hold_n"}, 2'd3);
    end
    pulse_step();
    check_status({tag, "_done"}, 2'd0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_actives("reset");
    check_status("reset", 2'd0);
    checks++;
    if (o_update !== 1'b0 || o_wr_ack !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got upd=%b ack=%b expected 0 0", o_update, o_wr_ack);
    end
  endtask

  task automatic test_basic_apply();
    do_write(3, 32'd7);
    check_status("basic_write", 2'd0);
    run_apply("basic");
    checks++;
    if (o_avg_sel !== 32'd7) begin
      errors++; $display("FAIL basic_avg got %0d expected 7", o_avg_sel);
    end
  endtask

  task automatic test_write_rules();
    do_write(3, 32'd9);
    check_status("avg_clamp", 2'd0);
    do_write(12, 32'hDEAD);
    check_status("bad_addr", 2'd0);
    clear_err();
    do_write(0, 32'd1);
    check_status("freq_low", 2'd0);
    clear_err();
    // Clamped avg and untouched freq must show up once committed
    run_apply("rules");
    checks++;
    if (o_avg_sel !== 32'd7 || o_freq_cnt !== 32'd221) begin
      errors++; $display("FAIL rules_commit got avg=%0d freq=%0d expected 7 221", o_avg_sel, o_freq_cnt);
    end
  endtask

  task automatic test_invalid_amp();
    do_write(1, 32'(-5000));
    run_apply("bad_amp");
    checks++;
    if (o_amp_H !== 32'd3000) begin
      errors++; $display("FAIL bad_amp_H got %0d expected 3000", $signed(o_amp_H));
    end
    clear_err();
    do_write(1, 32'd5000);
  endtask

  task automatic test_wait_clamp();
    do_write(0, 32'd100);
    run_apply("wait_keep");
    checks++;
    if (o_wait_cnt !== 32'd75) begin
      errors++; $display("FAIL wait_keep got %0d expected 75", o_wait_cnt);
    end
    do_write(6, 32'd150);
    run_apply("wait_clamp");
    checks++;
    if (o_wait_cnt !== 32'd99) begin
      errors++; $display("FAIL wait_clamp got %0d expected 99", o_wait_cnt);
    end
  endtask

  task automatic test_queued();
    bit valid;
    do_write(3, 32'd3);
    pulse_apply();
    check_status("q_armed", 2'd1);
    pulse_step();
    // Write lands during the APPLY cycle
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'd5;
    valid = model_apply();
    @(negedge clk);
    wr_en = 1'b0;
    model_write(3, 32'd5);
    checks++;
    if (o_update !== valid || o_avg_sel !== 32'd3 || o_wr_ack !== 1'b1) begin
      errors++; $display("FAIL q_first got upd=%b avg=%0d ack=%b expected 1 3 1", o_update, o_avg_sel, o_wr_ack);
    end
    check_status("q_hold", 2'd3);
    pulse_apply();
    pulse_step();
    pulse_step();
    check_status("q_hold_exit", 2'd0);
    @(negedge clk);
    check_status("q_rearmed", 2'd1);
    pulse_step();
    valid = model_apply();
    @(negedge clk);
    checks++;
    if (o_update !== valid || o_avg_sel !== 32'd5) begin
      errors++; $display("FAIL q_second got upd=%b avg=%0d expected 1 5", o_update, o_avg_sel);
    end
    compare_actives("q_second");
    pulse_step();
    pulse_step();
    @(negedge clk);
    check_status("q_consumed", 2'd0);
  endtask

  task automatic test_reset_armed();
    do_write(3, 32'd2);
    do_write(4, 32'd1234);
    pulse_apply();
    check_status("rst_armed", 2'd1);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    compare_actives("rst_async");
    check_status("rst_async", 2'd0);
    @(negedge clk) rst_n = 1'b1;
    pulse_step();
    @(negedge clk);
    checks++;
    if (o_update !== 1'b0) begin
      errors++; $display("FAIL rst_no_update got %b expected 0", o_update);
    end
    compare_actives("rst_after");
    check_status("rst_after", 2'd0);
  endtask

  task automatic test_random();
    int addr;
    logic [31:0] data;
    for (int it = 0; it < 12; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
        addr = int'($urandom_range(0, 8));
        case (addr)
          0:       data = $urandom_range(0, 300);
          1, 2:    data = 32'($urandom_range(0, 8000)) - 32'd4000;
          3:       data = $urandom_range(0, 12);
          6:       data = $urandom_range(0, 400);
          default: data = $urandom;
        endcase
        do_write(addr, data);
      end
      check_status("rand_writes", 2'd0);
      run_apply("rand");
      if (m_err) clear_err();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_apply();
    test_write_rules();
    test_invalid_amp();
    test_wait_clamp();
    test_queued();
    test_reset_armed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fog_param_sequencer.md
FOG_PARAM_SEQUENCER -- requirements
Module: fog_param_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_STEPS, default 2: number of step-trigger rising edges held busy after an apply.
REQ-002 SHALL have parameter AVG_MAX, default 7: maximum legal averaging select.
REQ-003 SHALL have port i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_wr_en  in  1  one-cycle host write strobe.
REQ-006 SHALL have port i_wr_addr  in  4  shadow register address.
REQ-007 SHALL have port i_wr_data  in  32  write data.
REQ-008 SHALL have port i_apply_req  in  1  one-cycle commit request.
REQ-009 SHALL have port i_step_trig  in  1  step trigger from the error-signal generator, same clock domain.
REQ-010 SHALL have port i_err_clr  in  1  clears o_err_flag.
REQ-011 SHALL have port o_wr_ack  out  1  one-cycle write acknowledge.
REQ-012 SHALL have ports o_freq_cnt, o_amp_H, o_amp_L, o_avg_sel, o_err_offset, o_wait_cnt  out  32 each  active parameters; o_polarity  out  1.
REQ-013 SHALL have port o_update  out  1  one-cycle pulse when active parameters change.
REQ-014 SHALL have ports o_busy  out  1; o_dirty  out  1; o_err_flag  out  1 sticky; o_state  out  2.

Function
REQ-015 Address map SHALL be: 0 freq_cnt, 1 amp_H, 2 amp_L, 3 avg_sel, 4 err_offset, 5 polarity (bit 0), 6 wait_cnt; amp_H, amp_L, err_offset signed two's complement.
REQ-016 Write SHALL update the shadow register on the i_wr_en cycle, set dirty, and pulse o_wr_ack the next cycle.
REQ-017 Write to addresses 7-15 SHALL still ack, leave shadows and dirty unchanged, and set o_err_flag.
REQ-018 Write of freq_cnt < 2 SHALL be rejected (shadow unchanged), acked, and set o_err_flag.
REQ-019 Write of avg_sel > AVG_MAX SHALL store AVG_MAX without error.
REQ-020 Step edge SHALL be detected as i_step_trig high with its registered previous value low.
REQ-021 FSM states SHALL be IDLE=0, ARMED=1, APPLY=2, HOLD=3, output on o_state.
REQ-022 IDLE -> ARMED on i_apply_req (or queued request) with dirty=1; apply request with dirty=0 SHALL be a no-op.
REQ-023 ARMED -> APPLY on step edge; ARMED SHALL wait indefinitely otherwise.
REQ-024 APPLY (one cycle) SHALL validate signed amp_H > amp_L; if valid, copy all shadows to active outputs, clear dirty, pulse o_update in the same cycle as the copy registers, go HOLD; if invalid, active unchanged, dirty kept, set o_err_flag, go IDLE.
REQ-025 On copy, if shadow wait_cnt >= shadow freq_cnt, active wait_cnt SHALL be freq_cnt-1 (shadow unchanged).
REQ-026 HOLD SHALL count SETTLE_STEPS step edges then go IDLE; SETTLE_STEPS=0 SHALL go IDLE the cycle after APPLY.
REQ-027 o_busy SHALL be 1 in ARMED, APPLY, HOLD.
REQ-028 i_apply_req while not IDLE SHALL set a single queued flag, serviced on IDLE entry, then cleared.
REQ-029 Write in the same cycle as APPLY SHALL land in the shadow, not the copy, and leave dirty=1.
REQ-030 i_err_clr SHALL clear o_err_flag; set condition in the same cycle SHALL win.

Reset
REQ-031 On i_rst_n low, asynchronously: shadows and actives freq_cnt=221, amp_H=3000, amp_L=-3000, avg_sel=6, err_offset=0, polarity=0, wait_cnt=75; state IDLE; dirty, queued, o_wr_ack, o_update, o_busy, o_err_flag, step history, HOLD counter all 0.
REQ-032 Reset asserted mid-ARMED/HOLD SHALL discard pending shadows and queued request.

Verification
REQ-033 Reset, write avg_sel=7, apply, step edge -> o_update one pulse, o_avg_sel=7, HOLD for 2 edges, then IDLE, o_busy=0.
REQ-034 Write avg_sel=9 -> shadow 7, no error; write addr 12 -> o_err_flag=1, ack pulses; i_err_clr -> 0.
REQ-035 Write amp_H=-5000 (amp_L=-3000), apply, step edge -> actives unchanged, o_err_flag=1, state IDLE, o_dirty=1.
REQ-036 Write freq_cnt=100 (wait_cnt=75 kept), apply -> o_wait_cnt=75; then wait_cnt=150, apply -> o_wait_cnt=99.
REQ-037 Apply during HOLD plus write in APPLY cycle -> second apply at next step edge after HOLD exit, carrying new value.
REQ-038 Reset pulsed while ARMED -> all outputs return to defaults immediately, no o_update on next step edge.
